// File: rtl/mig_maj_sequencer.sv
// Sequencer that runs one majority-inverter operation on a single-port SRAM:
// it reads three rows, inverts each one if asked, writes the majority and can read it back to verify.
module mig_maj_sequencer #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_src_a,
    input  logic [AW-1:0] cmd_src_b,
    input  logic [AW-1:0] cmd_src_c,
    input  logic [AW-1:0] cmd_dst,
    input  logic [2:0]    cmd_inv,
    input  logic          cmd_verify,
    output logic [AW-1:0] address_MIG,
    output logic          CS,
    output logic          WE,
    output logic          OE,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wdata_oe,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          verify_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_RA, S_RB, S_RC, S_CAP, S_WR, S_VR, S_VC, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_a_q, src_a_d, src_b_q, src_b_d, src_c_q, src_c_d, dst_q, dst_d;
    logic [2:0]    inv_q, inv_d;
    logic          verify_q, verify_d;
    logic [DW-1:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
    logic          verify_err_q, verify_err_d;
    logic [DW-1:0] maj_a, maj_b, maj_c;

    // Operand C is never stored: it is used straight off the bus in CAP.
    assign maj_a = op_a_q    ^ {DW{inv_q[0]}};
    assign maj_b = op_b_q    ^ {DW{inv_q[1]}};
    assign maj_c = mem_rdata ^ {DW{inv_q[2]}};

    always_comb begin
        state_d      = state_q;
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        src_c_d      = src_c_q;
        dst_d        = dst_q;
        inv_d        = inv_q;
        verify_d     = verify_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        result_d     = result_q;
        verify_err_d = verify_err_q;
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                src_a_d      = cmd_src_a;
                src_b_d      = cmd_src_b;
                src_c_d      = cmd_src_c;
                dst_d        = cmd_dst;
                inv_d        = cmd_inv;
                verify_d     = cmd_verify;
                verify_err_d = 1'b0;
                state_d      = S_RA;
            end
            S_RA:   state_d = S_RB;
            S_RB: begin
                op_a_d  = mem_rdata;
                state_d = S_RC;
            end
            S_RC: begin
                op_b_d  = mem_rdata;
                state_d = S_CAP;
            end
            S_CAP: begin
                result_d = (maj_a & maj_b) | (maj_a & maj_c) | (maj_b & maj_c);
                state_d  = S_WR;
            end
            S_WR:   state_d = verify_q ? S_VR : S_DONE;
            S_VR:   state_d = S_VC;
            S_VC: begin
                verify_err_d = (mem_rdata != result_q);
                state_d      = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            src_a_q      <= '0;
            src_b_q      <= '0;
            src_c_q      <= '0;
            dst_q        <= '0;
            inv_q        <= '0;
            verify_q     <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            result_q     <= '0;
            verify_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_a_q      <= src_a_d;
            src_b_q      <= src_b_d;
            src_c_q      <= src_c_d;
            dst_q        <= dst_d;
            inv_q        <= inv_d;
            verify_q     <= verify_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            result_q     <= result_d;
            verify_err_q <= verify_err_d;
        end
    end

    // SRAM controls are decoded from registered state only, so they fall to 0 as soon as reset is asserted.
    always_comb begin
        address_MIG  = '0;
        CS           = 1'b0;
        WE           = 1'b0;
        OE           = 1'b0;
        mem_wdata    = '0;
        mem_wdata_oe = 1'b0;
        case (state_q)
            S_RA: begin CS = 1'b1; OE = 1'b1; address_MIG = src_a_q; end
            S_RB: begin CS = 1'b1; OE = 1'b1; address_MIG = src_b_q; end
            S_RC: begin CS = 1'b1; OE = 1'b1; address_MIG = src_c_q; end
            S_WR: begin
                CS           = 1'b1;
                WE           = 1'b1;
                address_MIG  = dst_q;
                mem_wdata    = result_q;
                mem_wdata_oe = 1'b1;
            end
            S_VR: begin CS = 1'b1; OE = 1'b1; address_MIG = dst_q; end
            default: ;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign cmd_ready  = ~busy;
    assign done       = (state_q == S_DONE);
    assign result     = result_q;
    assign verify_err = verify_err_q;

endmodule

// File: tb/tb_mig_maj_sequencer.sv
// Directed bench for mig_maj_sequencer. It uses a behavioural SRAM with a read latency of 1 cycle,
// and writes to row 6 come back with bit 0 stuck at 1.
module tb_mig_maj_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_src_a = '0, cmd_src_b = '0, cmd_src_c = '0, cmd_dst = '0;
    logic [2:0]  cmd_inv = '0;
    logic        cmd_verify = 1'b0;
    logic [4:0]  address_MIG;
    logic        CS, WE, OE;
    logic [31:0] mem_wdata;
    logic        mem_wdata_oe;
    logic [31:0] mem_rdata = '0;
    logic        busy, done;
    logic [31:0] result;
    logic        verify_err;

    int n_assert = 0;
    int n_fail   = 0;

    mig_maj_sequencer #(.DW(32), .AW(5)) dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_src_c(cmd_src_c),
        .cmd_dst(cmd_dst), .cmd_inv(cmd_inv), .cmd_verify(cmd_verify),
        .address_MIG(address_MIG), .CS(CS), .WE(WE), .OE(OE),
        .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .result(result), .verify_err(verify_err)
    );

    always #5 clk = ~clk;

    // The SRAM model owns the array. The bench preloads rows through pl_*.
    logic [31:0] mem [0:31];
    logic        pl_en = 1'b0;
    logic [4:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          cyc = 0, we_cnt = 0, oe_err = 0, last_rd_cyc = 0, wr_cyc = 0;
    logic [4:0]  last_we_addr = '0, last_rd_addr = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (CS && WE) begin
            mem[address_MIG] <= (address_MIG == 5'd6) ? (mem_wdata | 32'h1) : mem_wdata;
            we_cnt       <= we_cnt + 1;
            last_we_addr <= address_MIG;
            wr_cyc       <= cyc;
        end
        if (CS && OE && !WE) begin
            mem_rdata    <= mem[address_MIG];
            last_rd_addr <= address_MIG;
            last_rd_cyc  <= cyc;
        end
        if (mem_wdata_oe != (CS && WE)) oe_err <= oe_err + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic set_cmd(input logic [4:0] a, b, c, d, input logic [2:0] inv, input logic ver);
        cmd_src_a = a; cmd_src_b = b; cmd_src_c = c; cmd_dst = d;
        cmd_inv = inv; cmd_verify = ver;
    endtask

    // The task returns when it sees done. lat counts cycles from the accept edge, where RA is cycle 1.
    task automatic run_cmd(input logic [4:0] a, b, c, d, input logic [2:0] inv,
                           input logic ver, output int lat);
        @(negedge clk);
        set_cmd(a, b, c, d, inv, ver);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat, we0, bad_ready, n;

    initial begin
        // Reset state
        #2;
        chk("rst_ctl", {CS, WE, OE, mem_wdata_oe, busy, done, verify_err}, 32'h0);
        chk("rst_addr_wdata", {27'd0, address_MIG} | mem_wdata, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_ready", cmd_ready, 1'b1);
        preload(5'd1, 32'hFFFF0000);
        preload(5'd2, 32'hFF00FF00);
        preload(5'd3, 32'hF0F0F0F0);
        preload(5'd9, 32'h12345678);
        preload(5'd10, 32'hDEADBEEF);
        @(negedge clk);
        rstn = 1'b1;

        // Plain majority without verify
        we0 = we_cnt;
        run_cmd(5'd1, 5'd2, 5'd3, 5'd4, 3'b000, 1'b0, lat);
        chk("t1_latency", lat, 6);
        chk("t1_result", result, 32'hFFF0F000);
        @(negedge clk);
        chk("t1_mem4", mem[4], 32'hFFF0F000);
        chk("t1_we_count", we_cnt - we0, 1);
        chk("t1_we_addr", last_we_addr, 5'd4);

        // Invert A, with verify
        run_cmd(5'd1, 5'd2, 5'd3, 5'd5, 3'b001, 1'b1, lat);
        chk("t2_latency", lat, 8);
        chk("t2_verify_err", verify_err, 1'b0);
        chk("t2_vr_addr", last_rd_addr, 5'd5);
        @(negedge clk);
        chk("t2_mem5", mem[5], 32'hF000FFF0);

        // Row 6 reads back wrong, so verify must flag the error
        run_cmd(5'd1, 5'd2, 5'd3, 5'd6, 3'b000, 1'b1, lat);
        chk("t3_verify_err", verify_err, 1'b1);
        @(negedge clk);
        chk("t3_err_held", verify_err, 1'b1);
        run_cmd(5'd1, 5'd2, 5'd3, 5'd12, 3'b000, 1'b0, lat);
        chk("t3_err_cleared", verify_err, 1'b0);
        chk("t3_latency", lat, 6);

        // Back-to-back commands with cmd_valid held high; the fields change while the first op is busy
        @(negedge clk);
        @(negedge clk);
        set_cmd(5'd1, 5'd2, 5'd3, 5'd7, 3'b000, 1'b0);
        cmd_valid = 1'b1;
        @(negedge clk);
        set_cmd(5'd1, 5'd2, 5'd3, 5'd8, 3'b001, 1'b0);
        bad_ready = 0;
        n = 1;
        while (!done && n < 20) begin
            if (cmd_ready || !busy) bad_ready++;
            @(negedge clk);
            n++;
        end
        chk("t4_first_latency", n, 6);
        chk("t4_ready_low_in_op", bad_ready, 0);
        @(negedge clk);
        chk("t4_idle_gap_ready", cmd_ready, 1'b1);
        @(negedge clk);
        chk("t4_second_accepted", busy, 1'b1);
        cmd_valid = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_second_latency", n, 6);
        @(negedge clk);
        chk("t4_mem7", mem[7], 32'hFFF0F000);
        chk("t4_mem8", mem[8], 32'hF000FFF0);

        // Aliasing: src_a = src_b = dst
        run_cmd(5'd9, 5'd9, 5'd3, 5'd9, 3'b000, 1'b0, lat);
        @(negedge clk);
        chk("t5_mem9", mem[9], 32'h12345678);
        chk("t5_reads_before_write", (last_rd_cyc < wr_cyc) ? 1 : 0, 1);

        // Reset asserted in RC aborts the op, and row 10 stays untouched
        @(negedge clk);
        set_cmd(5'd1, 5'd2, 5'd3, 5'd10, 3'b000, 1'b0);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_rc", {CS, OE, address_MIG}, {1'b1, 1'b1, 5'd3});
        we0 = we_cnt;
        rstn = 1'b0;
        #1;
        chk("t6_abort_ctl", {CS, WE, OE, mem_wdata_oe, busy}, 5'b0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_no_write", we_cnt - we0, 0);
        chk("t6_mem10", mem[10], 32'hDEADBEEF);
        run_cmd(5'd1, 5'd2, 5'd3, 5'd11, 3'b000, 1'b0, lat);
        chk("t6_next_latency", lat, 6);
        @(negedge clk);
        chk("t6_mem11", mem[11], 32'hFFF0F000);
        chk("bus_drive_only_in_wr", oe_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mig_maj_sequencer.md
Name: mig_maj_sequencer

Overview:
- Command-driven controller that runs one majority-inverter (MIG) operation on the vector register file SRAM: reads three source rows, optionally inverts each, and computes the bitwise 3-input majority.
- Writes the result to a destination row and can optionally read it back to verify it.
- Sits between a command source (top-level decoder or host FSM) and the single-port 32x32 SRAM (CS/WE/OE, 5-bit address, bidirectional 32-bit data).
- Drives the SRAM alone and exposes a separate write-data bus plus a drive-enable, which the top-level tristate uses.

Parameters:
DW, 32, SRAM word width in bits
AW, 5, SRAM address width in bits

Ports:
clk  input  1  clock; all logic rising-edge
rstn  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer idle and accepting; accept = cmd_valid & cmd_ready at rising edge
cmd_src_a  input  AW  address of operand A
cmd_src_b  input  AW  address of operand B
cmd_src_c  input  AW  address of operand C
cmd_dst  input  AW  destination address
cmd_inv  input  3  per-operand invert: bit0 A, bit1 B, bit2 C
cmd_verify  input  1  read back dst after write and compare
address_MIG  output  AW  SRAM address
CS  output  1  SRAM chip select
WE  output  1  SRAM write enable
OE  output  1  SRAM output enable
mem_wdata  output  DW  write data to tristate
mem_wdata_oe  output  1  drive enable for data bus (high only in WR)
mem_rdata  input  DW  SRAM read data; valid the cycle after a read is issued (latency 1)
busy  output  1  not in IDLE
done  output  1  one-cycle pulse, operation complete
result  output  DW  last computed majority word, held until next compute
verify_err  output  1  readback mismatch on last verified command

Behaviour:
- Reset (async, rstn=0): state=IDLE; address_MIG=0, CS=WE=OE=0, mem_wdata=0, mem_wdata_oe=0, busy=0, done=0, result=0, verify_err=0, operand/command registers=0. Reset mid-operation aborts immediately; no partial write completes after rstn rises.
- Control outputs are decoded only from registered state and command registers; no combinational path from cmd_* or mem_rdata to any output.
- Command fields are latched on accept; later changes on cmd_* are ignored until the next accept.
- States, one cycle each except IDLE:
  - IDLE: cmd_ready=1; CS=WE=OE=0. Accept -> RA. verify_err clears on accept.
  - RA: CS=1, OE=1, WE=0, address=src_a -> RB.
  - RB: read issued to src_b; capture mem_rdata into opA -> RC.
  - RC: read issued to src_c; capture opB -> CAP.
  - CAP: CS=0, OE=0; capture opC.
    - Compute a=opA^{DW{inv0}}, b=opB^{DW{inv1}}, c=mem_rdata^{DW{inv2}}.
    - Register result=(a&b)|(a&c)|(b&c) -> WR.
  - WR: CS=1, WE=1, OE=0, address=dst, mem_wdata=result, mem_wdata_oe=1 -> VR if verify else DONE.
  - VR: CS=1, OE=1, WE=0, address=dst, mem_wdata_oe=0 -> VC.
  - VC: CS=0; verify_err <= (mem_rdata != result) -> DONE.
  - DONE: done=1, busy=1, cmd_ready=0 -> IDLE.
- Latency from accept edge:
  - No verify: done high in the 6th cycle (RA RB RC CAP WR DONE).
  - With verify: done high in the 8th cycle.
- Back-to-back: with cmd_valid held high, the next accept occurs on the edge leaving IDLE, so there is one IDLE cycle between commands.
- The data bus is never driven in the cycle adjacent to a read: WR is always preceded by CAP (OE=0), and VR follows WR with mem_wdata_oe already low.
- Aliasing:
  - Sources may repeat (e.g. src_a=src_b) or equal dst. All three reads complete before the write.
  - MAJ(x,x,y)=x by construction.
- Address wraps naturally within AW bits; there are no reserved addresses.
- busy=1 in every non-IDLE state; cmd_ready=~busy.

Test Plan:
- Preload mem[1]=0xFFFF0000, mem[2]=0xFF00FF00, mem[3]=0xF0F0F0F0; cmd a=1, b=2, c=3, dst=4, inv=000, verify=0 -> mem[4]=0xFFF0F000, result=0xFFF0F000, done in cycle 6, exactly one WE pulse at address 4.
- Same operands with inv=001, dst=5, verify=1 -> mem[5]=0xF000FFF0, verify_err=0, done in cycle 8, read at address 5 in VR.
- Memory model forces bit0 of writes to address 6 to 1; cmd a=1, b=2, c=3, dst=6, verify=1 -> verify_err=1. Next accepted command clears it to 0.
- cmd_valid held high with two queued commands (dst=7, then dst=8), second command's fields changing while busy -> second accepted only after DONE+IDLE; cmd_ready=0 throughout the first op; second uses its own latched fields.
- Aliasing: mem[9]=0x12345678, cmd a=9, b=9, c=3, dst=9 -> mem[9]=0x12345678, with all reads before the write.
- Assert rstn=0 during RC of a command -> CS/WE/OE/mem_wdata_oe go 0 immediately, busy=0, no write to dst after release, and the next command runs normally.
